// File: rtl/stopwatch_uart_pkg.sv
// stopwatch_uart_pkg: command codes, report sizing and command-controller states
package stopwatch_uart_pkg;
    localparam logic [7:0] CMD_GO     = 8'h67;
    localparam logic [7:0] CMD_PAUSE  = 8'h70;
    localparam logic [7:0] CMD_CLEAR  = 8'h63;
    localparam logic [7:0] CMD_UPDN   = 8'h75;
    localparam logic [7:0] CMD_REPORT = 8'h72;
    localparam logic [7:0] CASE_MASK  = 8'h20;
    localparam int REPORT_LEN    = 7;
    localparam int REPORT_CYCLES = 8;
    typedef enum logic [2:0] {S_IDLE, S_ECHO, S_ACT, S_WAIT_SPACE, S_BUSY} state_t;
    function automatic logic [7:0] to_lower(input logic [7:0] c);
        return c | CASE_MASK;
    endfunction
endpackage

// File: rtl/stopwatch_uart_cmd_ctrl.sv
// stopwatch_uart_cmd_ctrl: RX command decoder, report scheduler and TX write-port arbiter
module stopwatch_uart_cmd_ctrl
    import stopwatch_uart_pkg::*;
#(
    parameter int TX_DEPTH = 16,
    parameter int TX_CW    = 5,
    parameter bit ECHO     = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_rx_empty,
    input  logic [7:0]       i_rx_data,
    output logic             o_rx_rd,
    input  logic             i_tx_full,
    input  logic [TX_CW-1:0] i_tx_count,
    output logic             o_tx_wr,
    output logic [7:0]       o_tx_data,
    output logic             o_report_start,
    input  logic             i_report_wr,
    input  logic [7:0]       i_report_ascii,
    output logic             o_run,
    output logic             o_up,
    output logic             o_clr
);
    localparam int CNT_W = $clog2(REPORT_CYCLES);
    localparam logic [TX_CW-1:0] MAX_FILL = TX_CW'(TX_DEPTH - REPORT_LEN);

    state_t           r_state;
    logic [7:0]       r_cmd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_run, r_up, r_clr;
    logic             w_busy, w_space_ok, w_echo_wr;
    logic [7:0]       w_lc;

    assign w_busy         = r_state == S_BUSY;
    assign w_space_ok     = i_tx_count <= MAX_FILL;
    assign w_echo_wr      = r_state == S_ECHO && !i_tx_full;
    assign w_lc           = to_lower(r_cmd);
    assign o_rx_rd        = r_state == S_IDLE && !i_rx_empty;
    assign o_report_start = r_state == S_WAIT_SPACE && w_space_ok;
    assign o_tx_wr        = w_busy ? i_report_wr : w_echo_wr;
    assign o_tx_data      = w_busy ? i_report_ascii : r_cmd;
    assign o_run          = r_run;
    assign o_up           = r_up;
    assign o_clr          = r_clr;

    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cmd   <= '0;
            r_cnt   <= '0;
            r_run   <= 1'b0;
            r_up    <= 1'b1;
            r_clr   <= 1'b0;
        end else begin
            r_clr <= 1'b0;
            case (r_state)
                S_IDLE: if (!i_rx_empty) begin
                    r_cmd   <= i_rx_data;
                    r_state <= ECHO ? S_ECHO : S_ACT;
                end
                S_ECHO: if (!i_tx_full) r_state <= S_ACT;
                S_ACT: begin
                    if (w_lc == CMD_GO) r_run <= 1'b1;
                    if (w_lc == CMD_PAUSE) r_run <= 1'b0;
                    if (w_lc == CMD_CLEAR) r_clr <= 1'b1;
                    if (w_lc == CMD_UPDN) r_up <= !r_up;
                    r_state <= w_lc == CMD_REPORT ? S_WAIT_SPACE : S_IDLE;
                end
                S_WAIT_SPACE: if (w_space_ok) begin
                    r_state <= S_BUSY;
                    r_cnt   <= CNT_W'(REPORT_CYCLES - 1);
                end
                S_BUSY: if (r_cnt == '0) r_state <= S_IDLE;
                        else r_cnt <= r_cnt - 1'b1;
                default: r_state <= S_IDLE;
            endcase
        end
endmodule

// File: tb/tb_stopwatch_uart_cmd_ctrl.sv
// tb_stopwatch_uart_cmd_ctrl: directed checks of the command controller with ECHO=1 and ECHO=0
module tb_stopwatch_uart_cmd_ctrl;
    logic       clk = 0, rst = 1;
    logic       rx_empty0 = 1, rx_empty1 = 1, tx_full = 0, inj_wr = 0, rep_wr = 0;
    logic [7:0] rx_data0 = 0, rx_data1 = 0, rep_byte = 0;
    logic [4:0] tx_count = 0;
    logic       report_wr;
    logic [7:0] report_ascii;
    logic       rx_rd0, tx_wr0, start0, run0, up0, clr0;
    logic       rx_rd1, tx_wr1, start1, run1, up1, clr1;
    logic [7:0] tx_data0, tx_data1;
    logic [7:0] rep_bytes [7] = '{8'h0A, 8'h31, 8'h2E, 8'h32, 8'h33, 8'h2E, 8'h34};
    logic [7:0] exp_r [9] = '{8'h72, 8'h0A, 8'h31, 8'h2E, 8'h32, 8'h33, 8'h2E, 8'h34, 8'h70};
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    int rep_wait = 0, rep_idx = -1, checks = 0, errors = 0, base, base0;

    assign report_wr    = rep_wr | inj_wr;
    assign report_ascii = rep_wr ? rep_byte : 8'h5A;

    always #5 clk = ~clk;

    stopwatch_uart_cmd_ctrl #(.TX_DEPTH(16), .TX_CW(5), .ECHO(1'b1)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_rx_empty(rx_empty0), .i_rx_data(rx_data0), .o_rx_rd(rx_rd0),
        .i_tx_full(tx_full), .i_tx_count(tx_count), .o_tx_wr(tx_wr0), .o_tx_data(tx_data0),
        .o_report_start(start0), .i_report_wr(report_wr), .i_report_ascii(report_ascii),
        .o_run(run0), .o_up(up0), .o_clr(clr0));

    stopwatch_uart_cmd_ctrl #(.TX_DEPTH(16), .TX_CW(5), .ECHO(1'b0)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_rx_empty(rx_empty1), .i_rx_data(rx_data1), .o_rx_rd(rx_rd1),
        .i_tx_full(tx_full), .i_tx_count(tx_count), .o_tx_wr(tx_wr1), .o_tx_data(tx_data1),
        .o_report_start(start1), .i_report_wr(report_wr), .i_report_ascii(report_ascii),
        .o_run(run1), .o_up(up1), .o_clr(clr1));

    // transmit-interface model: 7 writes starting two cycles after a start pulse, plus TX capture
    always @(negedge clk) begin
        if (rep_wait > 0) begin
            rep_wait--;
            if (rep_wait == 0) rep_idx = 0;
        end
        if (rep_idx >= 0 && rep_idx < 7) begin
            rep_wr   = 1;
            rep_byte = rep_bytes[rep_idx];
            rep_idx++;
        end else begin
            rep_wr  = 0;
            rep_idx = -1;
        end
        #4;
        if (tx_wr0) q0.push_back(tx_data0);
        if (tx_wr1) q1.push_back(tx_data1);
        if (start0 || start1) rep_wait = 2;
    end

    task automatic nx();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        repeat (2) nx();
        #1 chk("rst_run", run0, 0); chk("rst_up", up0, 1); chk("rst_clr", clr0, 0);
        chk("rst_txwr", tx_wr0, 0); chk("rst_txdata", tx_data0, 0); chk("rst_start", start0, 0);
        nx(); rst = 0;
        // 'g' with echo
        nx(); rx_empty0 = 0; rx_data0 = "g";
        #1 chk("g_pop", rx_rd0, 1); chk("g_nowr", tx_wr0, 0);
        nx(); rx_empty0 = 1;
        #1 chk("g_echo_wr", tx_wr0, 1); chk("g_echo_data", tx_data0, 8'h67); chk("g_one_pop", rx_rd0, 0);
        nx(); #1 chk("g_act_run", run0, 0);
        nx(); #1 chk("g_run", run0, 1); chk("g_up", up0, 1);
        // 'C' then 'U' back to back
        nx(); rx_empty0 = 0; rx_data0 = "C";
        #1 chk("C_pop", rx_rd0, 1);
        nx(); rx_data0 = "U";
        #1 chk("C_echo_wr", tx_wr0, 1); chk("C_echo", tx_data0, 8'h43); chk("C_no_pop", rx_rd0, 0);
        nx(); #1 chk("C_act_clr", clr0, 0); chk("C_act_no_pop", rx_rd0, 0);
        nx(); #1 chk("C_clr", clr0, 1); chk("U_pop", rx_rd0, 1);
        nx(); rx_empty0 = 1;
        #1 chk("C_clr_end", clr0, 0); chk("U_echo_wr", tx_wr0, 1); chk("U_echo", tx_data0, 8'h55);
        nx(); #1 chk("U_act_up", up0, 1);
        nx(); #1 chk("U_up", up0, 0);
        // 'x' no-op then 'p' with TX full for 5 cycles during echo
        nx(); rx_empty0 = 0; rx_data0 = "x";
        #1 chk("x_pop", rx_rd0, 1);
        nx(); rx_data0 = "p";
        #1 chk("x_echo", tx_data0, 8'h78); chk("x_echo_wr", tx_wr0, 1);
        nx();
        nx(); #1 chk("x_run", run0, 1); chk("x_up", up0, 0); chk("x_clr", clr0, 0); chk("p_pop", rx_rd0, 1);
        nx(); rx_empty0 = 1; tx_full = 1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("p_stall", tx_wr0, 0);
            nx();
        end
        tx_full = 0;
        #1 chk("p_echo_wr", tx_wr0, 1); chk("p_echo", tx_data0, 8'h70);
        nx(); #1 chk("p_act_run", run0, 1);
        nx(); #1 chk("p_run", run0, 0);
        // 'r' stalled on TX space, then report burst; a queued 'p' waits out BUSY
        base = q0.size();
        nx(); rx_empty0 = 0; rx_data0 = "r"; tx_count = 10;
        #1 chk("r_pop", rx_rd0, 1);
        nx(); rx_empty0 = 1;
        #1 chk("r_echo", tx_data0, 8'h72);
        nx(); #1 chk("r_act_start", start0, 0);
        for (int i = 0; i < 3; i++) begin
            nx(); #1 chk("r_stall", start0, 0);
        end
        nx(); tx_count = 9;
        #1 chk("r_start", start0, 1);
        nx(); tx_count = 0;
        #1 chk("r_start_pulse", start0, 0);
        nx(); rx_empty0 = 0; rx_data0 = "p";
        #1 chk("busy_no_pop", rx_rd0, 0);
        repeat (6) nx();
        #1 chk("busy_last_no_pop", rx_rd0, 0);
        nx(); #1 chk("idle_pop", rx_rd0, 1);
        nx(); rx_empty0 = 1;
        nx(); nx();
        #1 chk("r_q_len", q0.size() - base, 9);
        for (int i = 0; i < 9; i++) chk("r_byte", q0[base+i], exp_r[i]);
        // report strobes outside BUSY are dropped
        nx(); inj_wr = 1;
        #1 chk("inj_idle0", tx_wr0, 0); chk("inj_idle1", tx_wr1, 0);
        nx(); inj_wr = 0;
        // reset after three report writes
        base = q0.size();
        nx(); rx_empty0 = 0; rx_data0 = "r";
        nx(); rx_empty0 = 1;
        nx();
        nx(); #1 chk("r2_start", start0, 1);
        repeat (4) nx();
        #1 chk("r2_wr3", tx_wr0, 1); chk("r2_data3", tx_data0, 8'h2E);
        nx(); rst = 1;
        #1 chk("mrst_run", run0, 0); chk("mrst_up", up0, 1); chk("mrst_clr", clr0, 0);
        chk("mrst_txwr", tx_wr0, 0); chk("mrst_txdata", tx_data0, 0); chk("mrst_start", start0, 0);
        chk("mrst_rd", rx_rd0, 0);
        nx(); rst = 0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("post_rst_wr", tx_wr0, 0);
            nx();
        end
        #1 chk("r2_q_len", q0.size() - base, 4); chk("r2_last", q0[base+3], 8'h2E);
        // ECHO=0 build: uppercase 'R', no echo, 7-byte burst only
        base = q1.size();
        base0 = q0.size();
        nx(); rx_empty1 = 0; rx_data1 = "R";
        #1 chk("e0_pop", rx_rd1, 1);
        nx(); rx_empty1 = 1;
        #1 chk("e0_no_echo", tx_wr1, 0); chk("e0_act_no_pop", rx_rd1, 0);
        nx(); #1 chk("e0_start", start1, 1);
        repeat (10) nx();
        #1 chk("e0_q_len", q1.size() - base, 7);
        for (int i = 0; i < 7; i++) chk("e0_byte", q1[base+i], exp_r[i+1]);
        chk("e0_dut0_quiet", q0.size() - base0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
